hash_stub_responder: RTL

//  Responder end of the hash-memory protocol: consumes start/length requests from an initiator
//  (H-matrix generator, expanders), reads seed words out of the initiator's RAM, then streams

---
 rtl/hash_stub_responder_pkg.sv | 15 +
 rtl/hash_stub_responder_if.sv | 22 ++
 rtl/hash_stub_responder_mixer.sv | 16 +
 rtl/hash_stub_responder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/hash_stub_responder_pkg.sv
// hash_stub_responder_pkg: FSM states, mixer constants and length helpers for the hash stub
package hash_stub_responder_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ABSORB, ST_SQUEEZE, ST_WAIT_FD} state_t;
  localparam logic [63:0] INIT_CONST_DEF = 64'h6A09E667F3BCC908;
  localparam int ROT_ABS = 13;
  localparam int XS_L1 = 13;
  localparam int XS_R = 7;
  localparam int XS_L2 = 17;
  function automatic logic [31:0] word_cnt(input logic [31:0] bits);
    word_cnt = 32'((33'(bits) + 33'd31) >> 5);
  endfunction
  function automatic logic [31:0] low_mask(input logic [4:0] rem);
    low_mask = (rem == 5'd0) ? '1 : (32'd1 << rem) - 32'd1;
  endfunction
endpackage

// File: rtl/hash_stub_responder_if.sv
// hash_stub_responder_if: request, RAM-read, output-stream and release signals of the hash-memory protocol
interface hash_stub_responder_if #(parameter int AW = 2);
  logic          i_start;
  logic [31:0]   i_input_length;
  logic [31:0]   i_output_length;
  logic [AW-1:0] o_addr;
  logic          o_rd_en;
  logic [31:0]   i_data_in;
  logic [31:0]   o_data_out;
  logic          o_data_out_valid;
  logic          i_data_out_ready;
  logic          i_force_done;
  logic          o_force_done_ack;
  modport slave (
    input  i_start, i_input_length, i_output_length, i_data_in, i_data_out_ready, i_force_done,
    output o_addr, o_rd_en, o_data_out, o_data_out_valid, o_force_done_ack
  );
  modport master (
    output i_start, i_input_length, i_output_length, i_data_in, i_data_out_ready, i_force_done,
    input  o_addr, o_rd_en, o_data_out, o_data_out_valid, o_force_done_ack
  );
endinterface

// File: rtl/hash_stub_responder_mixer.sv
// hash_stub_responder_mixer: combinational absorb (rotl13 ^ {w,~w}) and xorshift64 squeeze steps
module hash_stub_responder_mixer
  import hash_stub_responder_pkg::*;
(
  input  logic [63:0] i_s,
  input  logic [31:0] i_w,
  output logic [63:0] o_absorb,
  output logic [63:0] o_xs
);
  logic [63:0] w_a;
  logic [63:0] w_b;
  assign o_absorb = ((i_s << ROT_ABS) | (i_s >> (64 - ROT_ABS))) ^ {i_w, ~i_w};
  assign w_a = i_s ^ (i_s << XS_L1);
  assign w_b = w_a ^ (w_a >> XS_R);
  assign o_xs = w_b ^ (w_b << XS_L2);
endmodule

// File: rtl/hash_stub_responder.sv
// hash_stub_responder: hash-memory responder stub (seed absorb, pseudo-random squeeze); HASH_STUB_CYCLE_CNT_EN adds o_busy_cycles
module hash_stub_responder
  import hash_stub_responder_pkg::*;
#(
  parameter int          IO_WIDTH      = 32,
  parameter int          MAX_RAM_DEPTH = 4,
  parameter string       PARAMETER_SET = "L1",
  parameter logic [63:0] INIT_CONST    = INIT_CONST_DEF
) (
  input logic                  clk,
  input logic                  rst_n,
  hash_stub_responder_if.slave bus
`ifdef HASH_STUB_CYCLE_CNT_EN
  ,
  output logic [31:0]          o_busy_cycles
`endif
);
  localparam int AW = (MAX_RAM_DEPTH > 1) ? $clog2(MAX_RAM_DEPTH) : 1;
  if (IO_WIDTH != 32 || PARAMETER_SET == "") begin : g_bad_cfg
    $error("hash_stub_responder supports only IO_WIDTH=32 and a non-empty PARAMETER_SET");
  end
  state_t      r_state;
  state_t      w_next;
  logic [63:0] r_s;
  logic [31:0] r_ni;
  logic [31:0] r_no;
  logic [4:0]  r_in_rem;
  logic [4:0]  r_out_rem;
  logic [31:0] r_rd_cnt;
  logic [31:0] r_cap_cnt;
  logic [31:0] r_out_cnt;
  logic        r_rd_d;
  logic        r_ack;
  logic [31:0] w_ni_req;
  logic [31:0] w_ni;
  logic [31:0] w_no;
  logic        w_rd_en;
  logic        w_last_cap;
  logic        w_last_out;
  logic        w_valid;
  logic        w_hs;
  logic [31:0] w_word;
  logic [31:0] w_fold;
  logic [63:0] w_abs_s;
  logic [63:0] w_xs_s;
  assign w_ni_req   = word_cnt(bus.i_input_length);
  assign w_ni       = (w_ni_req > 32'(MAX_RAM_DEPTH)) ? 32'(MAX_RAM_DEPTH) : w_ni_req;
  assign w_no       = word_cnt(bus.i_output_length);
  assign w_rd_en    = (r_state == ST_ABSORB) && (r_rd_cnt < r_ni);
  // RAM data lags o_rd_en by one cycle, so r_rd_d marks the capture cycles
  assign w_last_cap = (r_state == ST_ABSORB) && r_rd_d && (r_cap_cnt == r_ni - 32'd1);
  assign w_word     = bus.i_data_in & (w_last_cap ? low_mask(r_in_rem) : '1);
  assign w_valid    = (r_state == ST_SQUEEZE);
  assign w_hs       = w_valid && bus.i_data_out_ready;
  assign w_last_out = (r_out_cnt == r_no - 32'd1);
  assign w_fold     = (r_s[63:32] ^ r_s[31:0]) & (w_last_out ? low_mask(r_out_rem) : '1);
  hash_stub_responder_mixer u_mix (
    .i_s      (r_s),
    .i_w      (w_word),
    .o_absorb (w_abs_s),
    .o_xs     (w_xs_s)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (bus.i_start) w_next = (w_ni != 0) ? ST_ABSORB : (w_no != 0) ? ST_SQUEEZE : ST_WAIT_FD;
      ST_ABSORB:  if (bus.i_force_done) w_next = ST_IDLE;
                  else if (w_last_cap) w_next = (r_no != 0) ? ST_SQUEEZE : ST_WAIT_FD;
      ST_SQUEEZE: if (bus.i_force_done) w_next = ST_IDLE;
                  else if (w_hs && w_last_out) w_next = ST_WAIT_FD;
      default:    if (bus.i_force_done) w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s       <= INIT_CONST;
      r_ni      <= '0;
      r_no      <= '0;
      r_in_rem  <= '0;
      r_out_rem <= '0;
      r_rd_cnt  <= '0;
      r_cap_cnt <= '0;
      r_out_cnt <= '0;
      r_rd_d    <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_rd_d <= w_rd_en;
      r_ack  <= (r_state != ST_IDLE) && bus.i_force_done;
      if (r_state == ST_IDLE && bus.i_start) begin
        r_s       <= INIT_CONST ^ {32'd0, bus.i_input_length};
        r_ni      <= w_ni;
        r_no      <= w_no;
        r_in_rem  <= bus.i_input_length[4:0];
        r_out_rem <= bus.i_output_length[4:0];
        r_rd_cnt  <= '0;
        r_cap_cnt <= '0;
        r_out_cnt <= '0;
      end else if (r_state == ST_ABSORB) begin
        if (w_rd_en) r_rd_cnt <= r_rd_cnt + 32'd1;
        if (r_rd_d) begin
          r_s       <= w_abs_s;
          r_cap_cnt <= r_cap_cnt + 32'd1;
        end
      end else if (w_hs) begin
        r_s       <= w_xs_s;
        r_out_cnt <= r_out_cnt + 32'd1;
      end
    end
  assign bus.o_rd_en          = w_rd_en;
  assign bus.o_addr           = w_rd_en ? r_rd_cnt[AW-1:0] : '0;
  assign bus.o_data_out_valid = w_valid;
  assign bus.o_data_out       = w_valid ? w_fold : '0;
  assign bus.o_force_done_ack = r_ack;
`ifdef HASH_STUB_CYCLE_CNT_EN
  logic [31:0] r_busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_busy <= '0;
    else if (r_state == ST_IDLE && bus.i_start) r_busy <= '0;
    else if (r_state != ST_IDLE && r_busy != '1) r_busy <= r_busy + 32'd1;
  assign o_busy_cycles = r_busy;
`endif
endmodule
